uio_bus_arbiter: RTL
====================

UIO_BUS_ARBITER -- requirements
Module: uio_bus_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 2: number of cycles the bus is held per transfer, legal range 1..15.
REQ-002 Parameter TURN_CYCLES, default 1: bus-idle cycles inserted on a direction change, legal range 1..3.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 ena  in  1  design enable; low blocks new grants.
REQ-006 req  in  3  per-requester transfer request, level.
REQ-007 wr  in  3  per-requester direction: 1 = write to pins, 0 = read from pins.
REQ-008 wdata  in  24  write data; requester i uses bits [8i+7:8i].
REQ-009 uio_in  in  8  pad input path.
REQ-010 gnt  out  3  one-hot grant, high for the whole granted transfer.
REQ-011 done  out  3  one-hot, one-cycle completion pulse.
REQ-012 rdata  out  8  last read value captured from uio_in.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 uio_out  out  8  pad output path.
REQ-015 uio_oe  out  8  pad output enable, 1 = drive.

Function
REQ-016 FSM states IDLE, TURN, XFER; all outputs registered.
REQ-017 IDLE: if ena=1 and req!=0, grant the first requesting index after last_gnt in 0->1->2->0 order, latch index, wr bit and wdata slice, and set last_gnt to that index.
REQ-018 Grant decision: go to TURN if the latched wr differs from bus direction dir_q, else go to XFER; gnt goes high on the same edge.
REQ-019 TURN: uio_oe=0x00 and uio_out=0x00 for exactly TURN_CYCLES cycles; then update dir_q and go to XFER.
REQ-020 XFER write: uio_oe=0xFF and uio_out=latched data for exactly HOLD_CYCLES cycles.
REQ-021 XFER read: uio_oe=0x00 and uio_out=0x00; on the final XFER cycle edge, capture uio_in into rdata.
REQ-022 On the final XFER edge: state returns to IDLE, gnt clears, and done[idx] is high for one cycle.
REQ-023 A new grant may be decided in the same IDLE cycle that done is high, so back-to-back transfers lose no cycle.
REQ-024 Latency for same-direction traffic: req sampled at edge k -> gnt high after k -> done high after edge k+HOLD_CYCLES.
REQ-025 Latency for a direction change: add TURN_CYCLES.
REQ-026 req or wdata changes during a transfer are ignored; the transfer uses latched values; a dropped req still completes and pulses done.
REQ-027 ena falling mid-transfer does not abort the transfer; no grant is issued while ena=0.
REQ-028 Outside write XFER: uio_oe=0x00 and uio_out=0x00.
REQ-029 rdata holds its value until the next read completes.
REQ-030 The hold counter and turn counter are 4 bits, count down, and do not wrap.

Reset
REQ-031 rst=1 forces, immediately and without a clock: state=IDLE, gnt=000, done=000, busy=0, rdata=0x00, uio_out=0x00, uio_oe=0x00, dir_q=read, last_gnt=2.
REQ-032 rst asserted mid-transfer aborts the transfer with no done pulse and releases the pins the same instant.
REQ-033 After rst deasserts, the first grant decision occurs at the first rising edge with ena=1 and req!=0.

Verification
REQ-034 Reset, ena=1, req=111, wr=000, uio_in=0x5A -> grants in order 0,1,2; each gnt lasts 2 cycles; done pulses 001,010,100 back-to-back; rdata=0x5A; uio_oe stays 0x00.
REQ-035 After reset, req=010, wr=010, wdata[15:8]=0xC3 -> 1 TURN cycle with uio_oe=0x00, then 2 cycles of uio_oe=0xFF and uio_out=0xC3, then done=010.
REQ-036 Write by requester 0 followed by read by requester 1 -> uio_oe drops to 0x00 for exactly TURN_CYCLES cycles before the read XFER; rdata captured on the final XFER edge.
REQ-037 ena=0 with req=001 -> gnt stays 000 and busy=0; ena falling during XFER -> transfer completes and done pulses; no further grant.
REQ-038 rst pulsed during a write XFER -> uio_oe=0x00, gnt=000, no done pulse; the next grant after reset goes to requester 0.
REQ-039 HOLD_CYCLES=15 with req dropped after the grant cycle -> XFER lasts exactly 15 cycles and done still pulses.

Source files
------------

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter for three requesters sharing the bidirectional uio pad bus.
// Each granted transfer holds the bus for HOLD_CYCLES cycles. When the bus direction
// has to change, TURN_CYCLES idle cycles are inserted before the transfer.
// All outputs are registered.
module uio_bus_arbiter #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [2:0]  req,
    input  logic [2:0]  wr,
    input  logic [23:0] wdata,
    input  logic [7:0]  uio_in,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic [7:0]  uio_out,
    output logic [7:0]  uio_oe
);

    typedef enum logic [1:0] {StIdle, StTurn, StXfer} state_e;

    // Counters load N-1 so that a phase spans exactly N cycles.
    localparam logic [3:0] HoldInit = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] TurnInit = 4'(TURN_CYCLES - 1);

    state_e      state_q;
    logic [1:0]  idx_q;
    logic        wr_q;
    logic [7:0]  data_q;
    logic        dir_q;     // 1 = bus currently set up for writes
    logic [1:0]  last_gnt_q;
    logic [3:0]  cnt_q;

    logic        pick_valid;
    logic [1:0]  pick_idx;
    logic [7:0]  pick_data;
    int unsigned cand;

    // Round-robin pick: the first requester after last_gnt in 0->1->2->0 order.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        cand       = 0;
        // Walk from farthest to nearest so the nearest requester wins.
        for (int unsigned k = 3; k >= 1; k--) begin
            cand = (32'(last_gnt_q) + k) % 3;
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = 2'(cand);
            end
        end
        pick_data = wdata[8*pick_idx +: 8];
    end

    // Arbitration FSM with registered grant, completion and pad outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= 2'd0;
            wr_q       <= 1'b0;
            data_q     <= 8'h00;
            dir_q      <= 1'b0;
            last_gnt_q <= 2'd2;
            cnt_q      <= 4'd0;
            gnt        <= 3'b000;
            done       <= 3'b000;
            rdata      <= 8'h00;
            busy       <= 1'b0;
            uio_out    <= 8'h00;
            uio_oe     <= 8'h00;
        end else begin
            done <= 3'b000;
            unique case (state_q)
                StIdle: begin
                    if (ena && pick_valid) begin
                        idx_q      <= pick_idx;
                        wr_q       <= wr[pick_idx];
                        data_q     <= pick_data;
                        last_gnt_q <= pick_idx;
                        gnt        <= 3'b001 << pick_idx;
                        busy       <= 1'b1;
                        if (wr[pick_idx] != dir_q) begin
                            state_q <= StTurn;
                            cnt_q   <= TurnInit;
                            uio_oe  <= 8'h00;
                            uio_out <= 8'h00;
                        end else begin
                            state_q <= StXfer;
                            cnt_q   <= HoldInit;
                            uio_oe  <= wr[pick_idx] ? 8'hFF : 8'h00;
                            uio_out <= wr[pick_idx] ? pick_data : 8'h00;
                        end
                    end
                end
                StTurn: begin
                    if (cnt_q == 4'd0) begin
                        dir_q   <= wr_q;
                        state_q <= StXfer;
                        cnt_q   <= HoldInit;
                        uio_oe  <= wr_q ? 8'hFF : 8'h00;
                        uio_out <= wr_q ? data_q : 8'h00;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StXfer: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StIdle;
                        gnt     <= 3'b000;
                        done    <= 3'b001 << idx_q;
                        busy    <= 1'b0;
                        uio_oe  <= 8'h00;
                        uio_out <= 8'h00;
                        if (!wr_q) rdata <= uio_in;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
